// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions.
// FSM encodings and register constants.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic src_hit(
      input logic       use_src,
      input logic [4:0] src,
      input logic [4:0] dst
   );
      return use_src && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle.
// Pipeline status in, hold/bubble controls out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       ID_rs1;
   logic [4:0]       ID_rs2;
   logic             ID_use_rs1;
   logic             ID_use_rs2;
   logic [4:0]       EX_rd;
   logic             EX_is_load;
   logic             EX_redirect;
   logic             MEM_req;
   logic             MEM_ready;
   logic             IF_stall;
   logic             ID_stall;
   logic             EX_stall;
   logic             MEM_stall;
   logic             ID_flush;
   logic             EX_flush;
   logic             WB_flush;
   logic             mem_fault;
   logic [CNT_W-1:0] perf_stall_cycles;
   logic [CNT_W-1:0] perf_flush_count;

   modport master (
      output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
      output EX_rd, EX_is_load, EX_redirect,
      output MEM_req, MEM_ready,
      input  IF_stall, ID_stall, EX_stall, MEM_stall,
      input  ID_flush, EX_flush, WB_flush, mem_fault,
      input  perf_stall_cycles, perf_flush_count
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
      input  EX_rd, EX_is_load, EX_redirect,
      input  MEM_req, MEM_ready,
      output IF_stall, ID_stall, EX_stall, MEM_stall,
      output ID_flush, EX_flush, WB_flush, mem_fault,
      output perf_stall_cycles, perf_flush_count
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // count up until all-ones, then hold
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline hazard controller.
// Load-use bubbles, redirect squash, memory-wait hold and timeout fault.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

   state_t          state, state_nx;
   logic [WC_W-1:0] wait_cnt, wait_nx;
   logic            fault_q, fault_nx;

   logic mem_wait;
   logic load_use;
   logic stall_if, stall_id, stall_ex, stall_mem;
   logic flush_id, flush_ex, flush_wb;

   assign mem_wait = hz.MEM_req & ~hz.MEM_ready;

   assign load_use = hz.EX_is_load
                   & (hz.EX_rd != REG_ZERO)
                   & (src_hit(hz.ID_use_rs1, hz.ID_rs1, hz.EX_rd)
                    | src_hit(hz.ID_use_rs2, hz.ID_rs2, hz.EX_rd));

   // state, wait counter and sticky fault registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         fault_q  <= fault_nx;
      end
   end

   // next state plus prioritised hold/bubble controls
   always_comb begin
      state_nx  = state;
      wait_nx   = wait_cnt;
      fault_nx  = fault_q;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      flush_wb  = 1'b0;

      if (rst) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
         flush_wb = 1'b1;
      end else if (state == FAULT || mem_wait) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
         flush_wb  = 1'b1;
      end else if (hz.EX_redirect) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (load_use) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end

      case (state)
         RUN: begin
            if (mem_wait) begin
               state_nx = MEM_WAIT;
               wait_nx  = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!mem_wait) begin
               state_nx = RUN;
               wait_nx  = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nx = FAULT;
               fault_nx = 1'b1;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
         end
         FAULT: begin
            state_nx = FAULT;
         end
         default: begin
            state_nx = RUN;
            wait_nx  = '0;
         end
      endcase
   end

   assign hz.IF_stall  = stall_if;
   assign hz.ID_stall  = stall_id;
   assign hz.EX_stall  = stall_ex;
   assign hz.MEM_stall = stall_mem;
   assign hz.ID_flush  = flush_id;
   assign hz.EX_flush  = flush_ex;
   assign hz.WB_flush  = flush_wb;
   assign hz.mem_fault = fault_q & ~rst;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_if & ~rst),
      .count (hz.perf_stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_id & ~rst),
      .count (hz.perf_flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed plan steps, then random traffic
// against a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int TMO   = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   int  m_wait  = 0;
   bit  m_fault = 1'b0;
   int  m_stall = 0;
   int  m_flush = 0;
   bit  m_known = 1'b0;

   hazard_ctrl_if #(.CNT_W(CW)) hz ();

   hazard_ctrl #(
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, check against model, advance model
   task automatic cyc(
      input string    tag,
      input bit       r,
      input bit [4:0] rs1,
      input bit [4:0] rs2,
      input bit       u1,
      input bit       u2,
      input bit [4:0] rd,
      input bit       ld,
      input bit       redir,
      input bit       req,
      input bit       rdy
   );
      bit       mw, lu;
      bit [7:0] exp, obs;
      @(negedge clk);
      rst            = r;
      hz.ID_rs1      = rs1;
      hz.ID_rs2      = rs2;
      hz.ID_use_rs1  = u1;
      hz.ID_use_rs2  = u2;
      hz.EX_rd       = rd;
      hz.EX_is_load  = ld;
      hz.EX_redirect = redir;
      hz.MEM_req     = req;
      hz.MEM_ready   = rdy;
      #1;
      mw = req && !rdy;
      lu = ld && rd != 0 &&
           ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      // {IF,ID,EX,MEM stall, ID,EX,WB flush, fault}
      if (r)            exp = 8'b0000_1110;
      else if (m_fault) exp = 8'b1111_0011;
      else if (mw)      exp = 8'b1111_0010;
      else if (redir)   exp = 8'b0000_1100;
      else if (lu)      exp = 8'b1100_0100;
      else              exp = 8'b0000_0000;
      obs = {hz.IF_stall, hz.ID_stall, hz.EX_stall,
             hz.MEM_stall, hz.ID_flush, hz.EX_flush,
             hz.WB_flush, hz.mem_fault};
      chk({tag, ".ctl"}, int'(obs), int'(exp));
      if (m_known) begin
         chk({tag, ".stalls"},
             int'(hz.perf_stall_cycles), m_stall);
         chk({tag, ".flushes"},
             int'(hz.perf_flush_count), m_flush);
      end
      @(posedge clk);
      if (r) begin
         m_fault = 1'b0;
         m_wait  = 0;
         m_stall = 0;
         m_flush = 0;
         m_known = 1'b1;
      end else begin
         if (exp[7] && m_stall < CMAX) m_stall++;
         if (exp[3] && m_flush < CMAX) m_flush++;
         if (!m_fault) begin
            if (mw) begin
               m_wait++;
               if (m_wait == TMO) m_fault = 1'b1;
            end else begin
               m_wait = 0;
            end
         end
      end
   endtask

   initial begin
      // reset
      cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // load-use on rs2, then x0 destination
      cyc("lu",    0, 1, 5, 0, 1, 5, 1, 0, 0, 0);
      cyc("lu_nx", 0, 1, 5, 0, 1, 3, 0, 0, 0, 0);
      cyc("lu_x0", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("lu_b1", 0, 7, 2, 1, 0, 7, 1, 0, 0, 0);
      cyc("lu_b2", 0, 9, 2, 1, 0, 9, 1, 0, 0, 0);
      cyc("lu_nu", 0, 4, 4, 0, 0, 4, 1, 0, 0, 0);

      // redirect wins over load-use
      cyc("rd_lu", 0, 6, 0, 1, 0, 6, 1, 1, 0, 0);
      cyc("rd_af", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 3-cycle memory wait
      cyc("rst2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("mw1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("mw2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("mw3",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("mw_rd", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc("mw_af", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // redirect frozen through a 2-cycle wait
      cyc("rw1",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc("rw2",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc("rw_rd", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc("rw_af", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // illegal drop of MEM_req restarts the wait count
      cyc("dr1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("dr2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("dr3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("dr4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("dr5", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("dr6", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("dr7", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // timeout: 4 wait cycles then sticky fault
      for (int i = 0; i < TMO; i++)
         cyc("tmo_w", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("tmo_f1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc("tmo_f2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("tmo_f3", 0, 3, 0, 1, 0, 3, 1, 0, 0, 0);
      cyc("tmo_rs", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("tmo_ok", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // stall counter saturation
      for (int i = 0; i < 20; i++)
         cyc("sat", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("sat_rs", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // flush counter saturation
      for (int i = 0; i < 20; i++)
         cyc("fsat", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("fsat_rs", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bit slow;
         slow = ((i / 60) % 2) == 1;
         cyc("rnd",
             $urandom_range(0, 60) == 0,
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             1'($urandom),
             1'($urandom),
             5'($urandom_range(0, 3)),
             1'($urandom),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) < 4,
             slow ? ($urandom_range(0, 9) == 0)
                  : ($urandom_range(0, 1) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
